mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Single-port memory arbiter and sequencer for the five-stage pipelined CPU. Shares one unified instruction/data memory port between the IF stage (instruction fetch) and the MEM stage (data load/store). Serialises both onto a req/gnt/rvalid memory handshake with one outstanding transaction, and produces the pipeline stall that freezes PC, IF_ID, ID_EX and EX_MEM while an access is pending.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles from grant to rvalid before err_o is set; must be ≥2

- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held with if_addr_i until if_ready_o or if_flush_i
- if_addr_i  in  ADDR_W  fetch address (PC)
- if_flush_i  in  1  branch/jump taken: abandon the current fetch
- if_ready_o  out  1  one-cycle pulse: if_rdata_o valid
- if_rdata_o  out  DATA_W  fetched instruction
- d_req_i  in  1  data request; held with d_we_i, d_addr_i, d_wdata_i until d_ready_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address (EX_MEM ALU result)
- d_wdata_i  in  DATA_W  store data
- d_ready_o  out  1  one-cycle pulse: access complete; d_rdata_o valid for loads
- d_rdata_o  out  DATA_W  load data
- stall_o  out  1  (if_req_i & ~if_ready_o & ~if_flush_i) | (d_req_i & ~d_ready_o); combinational
- mem_req_o  out  1  memory request
- mem_we_o, mem_addr_o, mem_wdata_o  out  1/ADDR_W/DATA_W  request payload
- mem_gnt_i  in  1  memory accepted the request this cycle
- mem_rvalid_i  in  1  response/write-ack valid
- mem_rdata_i  in  DATA_W  read data
- err_o  out  1  sticky: response timeout

## Operation
- FSM states: IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D.
- IDLE: if d_req_i, go to REQ_D. Else if if_req_i & ~if_flush_i, go to REQ_I. Data has fixed priority (it is the older instruction). Payload is latched on the transition.
- REQ_x: mem_req_o=1 with the latched payload. Request is never withdrawn before mem_gnt_i. On gnt, go to WAIT_x. On gnt & rvalid in the same cycle, complete directly.
- WAIT_x: on mem_rvalid_i, register rdata, pulse the matching ready next cycle, and go to IDLE.
- A second d_req_i arriving during a fetch waits; it is taken in the IDLE cycle after the fetch completes.
- Flush: if_flush_i in REQ_I/WAIT_I sets the drop flag. The transaction still completes on the bus, but if_ready_o is suppressed. Flush in IDLE has no effect on the FSM.
- Response handling:
  - mem_rvalid_i in IDLE/REQ_x is ignored.
  - Stores complete on rvalid; d_rdata_o is unchanged.
- Timeout: a counter runs in WAIT_x. When it reaches TIMEOUT, err_o=1 (sticky until reset) and the FSM returns to IDLE with no ready pulse.

## Timing
- Reset (async assert, sync release): state IDLE; mem_req_o, mem_we_o, if_ready_o, d_ready_o, err_o = 0; mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o = 0; drop flag and counter cleared. A response in flight across reset is ignored.
- Minimum latency, zero-wait memory: request seen cycle 0, mem_req_o cycle 1, gnt+rvalid cycle 1, ready pulse cycle 2.
- mem_req_o, mem payload and ready/rdata outputs are registered; only stall_o is combinational.
- Ready pulses exactly one cycle. The requester must drop or change its request in the cycle after ready, otherwise it is served again.
- Timeout counter is $clog2(TIMEOUT+1) bits, saturating, cleared on entry to WAIT_x.

## Structure
- Package cpu_mem_pkg: state enum (IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D), default ADDR_W/DATA_W constants.
- One sub-module: mem_timeout_cnt (clear, enable, TIMEOUT parameter, expired output).
- CPU instantiates the arbiter between the PC/Instruction_Memory path and the DataMemory path. stall_o gates PCWrite and all pipeline register writes.

## Test plan
- Fetch only, zero-wait memory (gnt+rvalid with mem_req_o), addr 0x0000_0004, rdata 0x8C22_0000 -> mem_req_o cycle 1, if_ready_o cycle 2 with 0x8C22_0000, stall_o high cycles 0–1.
- d_req_i and if_req_i in the same cycle, load from 0x10 -> memory sees data addr 0x10 first, then the fetch. d_ready_o precedes if_ready_o; stall_o stays high until if_ready_o.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt -> mem_req_o/payload stable for all 4 request cycles; exactly one ready pulse.
- if_flush_i in WAIT_I -> no if_ready_o; next IDLE accepts the new if_addr_i fetch.
- No rvalid for 64 cycles after gnt -> err_o=1, FSM in IDLE. Then assert rst_n_i=0 mid-fetch -> all outputs 0 immediately; a late rvalid is ignored.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the unified instruction/data memory port.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        WAIT_I,
        REQ_D,
        WAIT_D
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
// slave: the arbiter's view; master: the pipeline stages plus the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W_DEF,
    parameter int DATA_W = cpu_mem_pkg::DATA_W_DEF
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_ready_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ready_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_ready_o, if_rdata_o, d_ready_o, d_rdata_o, stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_ready_o, if_rdata_o, d_ready_o, d_rdata_o, stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Purpose: counts cycles spent waiting for a memory response, flags TIMEOUT.
// Latency: expired is combinational from the registered count.
// Backpressure: none; saturates at TIMEOUT until cleared.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: serialises IF fetches and MEM loads/stores onto one req/gnt/rvalid port.
// Latency: request seen cycle 0, mem_req_o cycle 1, ready pulse one cycle after rvalid.
// Backpressure: holds mem_req_o until gnt; stall_o freezes the pipeline until ready.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    mem_port_arbiter_if.slave bus
);
    arb_state_t        state_q, state_d;
    logic              req_q, we_q, drop_q, i_rdy_q, d_rdy_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
    logic              d_take, i_take, in_req, in_wait, is_fetch, done, expired, tmo;

    // A requester still holding its line during its own ready pulse is not re-served.
    assign d_take   = bus.d_req_i & ~d_rdy_q;
    assign i_take   = bus.if_req_i & ~i_rdy_q & ~bus.if_flush_i;
    assign in_req   = (state_q == REQ_I) || (state_q == REQ_D);
    assign in_wait  = (state_q == WAIT_I) || (state_q == WAIT_D);
    assign is_fetch = (state_q == REQ_I) || (state_q == WAIT_I);
    assign done     = (in_req & bus.mem_gnt_i & bus.mem_rvalid_i) | (in_wait & bus.mem_rvalid_i);
    assign tmo      = in_wait & ~bus.mem_rvalid_i & expired;

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (~in_wait),
        .enable  (in_wait),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_take)      state_d = REQ_D;
                else if (i_take) state_d = REQ_I;
            end
            REQ_I:  if (bus.mem_gnt_i) state_d = bus.mem_rvalid_i ? IDLE : WAIT_I;
            REQ_D:  if (bus.mem_gnt_i) state_d = bus.mem_rvalid_i ? IDLE : WAIT_D;
            WAIT_I, WAIT_D: if (bus.mem_rvalid_i || expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            drop_q    <= 1'b0;
            i_rdy_q   <= 1'b0;
            d_rdy_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            i_rdy_q <= 1'b0;
            d_rdy_q <= 1'b0;
            if (state_q == IDLE) begin
                drop_q <= 1'b0;
                if (d_take) begin
                    req_q   <= 1'b1;
                    we_q    <= bus.d_we_i;
                    addr_q  <= bus.d_addr_i;
                    wdata_q <= bus.d_wdata_i;
                end else if (i_take) begin
                    req_q  <= 1'b1;
                    we_q   <= 1'b0;
                    addr_q <= bus.if_addr_i;
                end
            end
            if (in_req && bus.mem_gnt_i) req_q <= 1'b0;
            // A flushed fetch still finishes on the bus; only its ready is dropped.
            if (is_fetch && bus.if_flush_i) drop_q <= 1'b1;
            if (done && is_fetch && !drop_q && !bus.if_flush_i) begin
                i_rdy_q   <= 1'b1;
                i_rdata_q <= bus.mem_rdata_i;
            end
            if (done && !is_fetch) begin
                d_rdy_q <= 1'b1;
                if (!we_q) d_rdata_q <= bus.mem_rdata_i;
            end
            if (tmo) err_q <= 1'b1;
        end
    end

    assign bus.stall_o     = i_take | d_take;
    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.if_ready_o  = i_rdy_q;
    assign bus.if_rdata_o  = i_rdata_q;
    assign bus.d_ready_o   = d_rdy_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.err_o       = err_q;

endmodule
